// File: rtl/settings_pkg.sv
// Shared types and constants for the memory-checker test sequencer and its address generator.
package settings_pkg;

    localparam int unsigned ADDR_W        = 6;
    localparam int unsigned AMM_BURST_W   = 11;
    localparam int unsigned BYTE_PER_WORD = 16;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0, 2, 3, 5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef enum logic [1:0] {
        TestNone         = 2'd0,
        TestReadOnly     = 2'd1,
        TestWriteOnly    = 2'd2,
        TestWriteAndCheck = 2'd3
    } test_mode_type;

    typedef enum logic [2:0] {
        AddrFix  = 3'd0,
        AddrInc  = 3'd1,
        AddrRun1 = 3'd2,
        AddrRun0 = 3'd3,
        AddrRnd  = 3'd4
    } addr_mode_type;

    typedef enum logic {
        DataFixed = 1'b0,
        DataLfsr  = 1'b1
    } data_mode_type;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StIssue,
        StDrain,
        StDone
    } seq_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]        addr;
        logic [AMM_BURST_W-1:0]   burst;
        logic [BYTE_PER_WORD-1:0] start_mask;
        logic [BYTE_PER_WORD-1:0] end_mask;
        logic [7:0]               data_ptrn;
        data_mode_type            data_ptrn_type;
    } pkt_struct_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {^(cur & LFSR_TAPS), cur[15:1]};
    endfunction

endpackage

// File: rtl/mem_test_addr_gen.sv
// Mode-selected word-address generator. addr_o reflects this cycle's load/advance strobes so the
// caller can register the new address on the same edge that applies them.
module mem_test_addr_gen
    import settings_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              adv_i,
    input  addr_mode_type     mode_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] step_i,
    output logic [ADDR_W-1:0] addr_o
);

    localparam int unsigned       RunW    = $clog2(ADDR_W);
    localparam logic [RunW-1:0]   RunLast = RunW'(ADDR_W - 1);
    localparam logic [ADDR_W-1:0] One     = ADDR_W'(1);

    logic [ADDR_W-1:0] inc_q, inc_d;
    logic [RunW-1:0]   run_q, run_d;
    logic [15:0]       lfsr_q, lfsr_d;

    always_comb begin
        inc_d  = inc_q;
        run_d  = run_q;
        lfsr_d = lfsr_q;
        if (load_i) begin
            inc_d  = base_i;
            run_d  = '0;
            lfsr_d = LFSR_SEED;
        end else if (adv_i) begin
            inc_d  = inc_q + step_i;
            run_d  = (run_q == RunLast) ? '0 : run_q + RunW'(1);
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_comb begin
        case (mode_i)
            AddrInc:  addr_o = inc_d;
            AddrRun1: addr_o = One << run_d;
            AddrRun0: addr_o = ~(One << run_d);
            AddrRnd:  addr_o = lfsr_d[ADDR_W-1:0];
            default:  addr_o = base_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inc_q  <= '0;
            run_q  <= '0;
            lfsr_q <= LFSR_SEED;
        end else begin
            inc_q  <= inc_d;
            run_q  <= run_d;
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/mem_test_sequencer.sv
// Sequences one memory-checker run: latches settings on start, issues the packet stream and
// reports done once every read has returned. Field widths come from settings_pkg.
module mem_test_sequencer
    import settings_pkg::*;
#(
    parameter int unsigned OUTST_W = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     stop_i,
    input  test_mode_type            test_mode_i,
    input  addr_mode_type            addr_mode_i,
    input  data_mode_type            data_mode_i,
    input  logic [ADDR_W-1:0]        base_addr_i,
    input  logic [AMM_BURST_W-1:0]   burst_i,
    input  logic [31:0]              trans_cnt_i,
    input  logic [BYTE_PER_WORD-1:0] start_mask_i,
    input  logic [BYTE_PER_WORD-1:0] end_mask_i,
    input  logic [7:0]               data_ptrn_i,
    output logic                     pkt_valid_o,
    input  logic                     pkt_ready_i,
    output pkt_struct_t              pkt_o,
    output logic                     pkt_wr_o,
    input  logic                     rd_cpl_i,
    output logic                     busy_o,
    output logic                     done_o
);

    seq_state_e               state_q;
    test_mode_type            test_mode_q;
    addr_mode_type            addr_mode_q;
    data_mode_type            data_mode_q;
    logic [ADDR_W-1:0]        base_q;
    logic [AMM_BURST_W-1:0]   burst_q;
    logic [31:0]              trans_q, pkt_cnt_q;
    logic [BYTE_PER_WORD-1:0] smask_q, emask_q;
    logic [7:0]               ptrn_q;
    logic [OUTST_W-1:0]       outst_q, outst_d;
    pkt_struct_t              pkt_q;
    logic                     valid_q, wr_q, busy_q, done_q;

    logic              hs, rd_hs, pkt_done, last_pkt, gen_load, gen_adv, outst_dec;
    logic              next_wr, can_issue;
    logic [ADDR_W-1:0] gen_addr;

    mem_test_addr_gen u_addr_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (gen_load),
        .adv_i  (gen_adv),
        .mode_i (addr_mode_q),
        .base_i (base_q),
        .step_i (burst_q[ADDR_W-1:0]),
        .addr_o (gen_addr)
    );

    always_comb begin
        hs        = valid_q & pkt_ready_i;
        rd_hs     = hs & ~wr_q;
        // A write-and-check pair only counts as one packet once its read half is accepted.
        pkt_done  = hs & (~wr_q | (test_mode_q != TestWriteAndCheck));
        last_pkt  = pkt_done & ((pkt_cnt_q + 32'd1) == trans_q);
        gen_load  = (state_q == StLoad);
        gen_adv   = (state_q == StIssue) & pkt_done & ~last_pkt;
        outst_dec = rd_cpl_i & (outst_q != '0);
        outst_d   = outst_q + OUTST_W'(rd_hs) - OUTST_W'(outst_dec);
        case (test_mode_q)
            TestReadOnly:  next_wr = 1'b0;
            TestWriteOnly: next_wr = 1'b1;
            default:       next_wr = (state_q == StLoad) ? 1'b1 : (wr_q ^ hs);
        endcase
        // Never offer a read that could overflow the outstanding counter.
        can_issue = next_wr | (outst_d != '1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            test_mode_q <= TestNone;
            addr_mode_q <= AddrFix;
            data_mode_q <= DataFixed;
            base_q      <= '0;
            burst_q     <= '0;
            trans_q     <= '0;
            pkt_cnt_q   <= '0;
            smask_q     <= '0;
            emask_q     <= '0;
            ptrn_q      <= '0;
            outst_q     <= '0;
            pkt_q       <= '0;
            valid_q     <= 1'b0;
            wr_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (stop_i && (state_q != StIdle)) begin
            state_q <= StIdle;
            outst_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            outst_q <= outst_d;
            done_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i && (test_mode_i != TestNone)) begin
                        test_mode_q <= test_mode_i;
                        addr_mode_q <= addr_mode_i;
                        data_mode_q <= data_mode_i;
                        base_q      <= base_addr_i;
                        burst_q     <= burst_i;
                        trans_q     <= trans_cnt_i;
                        smask_q     <= start_mask_i;
                        emask_q     <= end_mask_i;
                        ptrn_q      <= data_ptrn_i;
                        busy_q      <= 1'b1;
                        state_q     <= StLoad;
                    end
                end
                StLoad: begin
                    pkt_cnt_q <= '0;
                    pkt_q     <= '{addr: gen_addr, burst: burst_q, start_mask: smask_q,
                                   end_mask: emask_q, data_ptrn: ptrn_q,
                                   data_ptrn_type: data_mode_q};
                    wr_q      <= next_wr;
                    if (trans_q == '0) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= StIssue;
                        valid_q <= can_issue;
                    end
                end
                StIssue: begin
                    if (pkt_done) pkt_cnt_q <= pkt_cnt_q + 32'd1;
                    if (last_pkt) begin
                        valid_q <= 1'b0;
                        state_q <= StDrain;
                    end else begin
                        if (hs) begin
                            pkt_q.addr <= gen_addr;
                            wr_q       <= next_wr;
                        end
                        valid_q <= (valid_q & ~hs) | can_issue;
                    end
                end
                StDrain: begin
                    if (outst_q == '0) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign pkt_valid_o = valid_q;
    assign pkt_o       = pkt_q;
    assign pkt_wr_o    = wr_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_mem_test_sequencer.sv
// Self-checking bench: a packet-list reference model predicts every output each cycle.
module tb_mem_test_sequencer;
    import settings_pkg::*;

    localparam int PIdle = 0, PLoad = 1, PIssue = 2, PDrain = 3, PDone = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst, start, stop, ready, rd_cpl;
    test_mode_type            tmode;
    addr_mode_type            amode;
    data_mode_type            dmode;
    logic [ADDR_W-1:0]        base;
    logic [AMM_BURST_W-1:0]   burst;
    logic [31:0]              cnt;
    logic [BYTE_PER_WORD-1:0] smask, emask;
    logic [7:0]               ptrn;
    logic                     valid, wr, busy, done;
    pkt_struct_t              pkt;

    mem_test_sequencer #(.OUTST_W(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .stop_i       (stop),
        .test_mode_i  (tmode),
        .addr_mode_i  (amode),
        .data_mode_i  (dmode),
        .base_addr_i  (base),
        .burst_i      (burst),
        .trans_cnt_i  (cnt),
        .start_mask_i (smask),
        .end_mask_i   (emask),
        .data_ptrn_i  (ptrn),
        .pkt_valid_o  (valid),
        .pkt_ready_i  (ready),
        .pkt_o        (pkt),
        .pkt_wr_o     (wr),
        .rd_cpl_i     (rd_cpl),
        .busy_o       (busy),
        .done_o       (done)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              wr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0, errors = 0;
    int   m_phase, m_outst;
    logic m_valid, m_busy, m_done;
    logic [AMM_BURST_W-1:0]   e_burst;
    logic [BYTE_PER_WORD-1:0] e_smask, e_emask;
    logic [7:0]               e_ptrn;
    logic                     e_dmode;
    int   cyc = 0, start_cyc, first_valid_cyc, done_cyc, last_hs_cyc;
    int   run_hs, run_rd, cpl_eff;
    int   lit_inc[5]  = '{3, 7, 11, 15, 19};
    int   lit_run1[8] = '{1, 2, 4, 8, 16, 32, 1, 2};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Whole run as a list of (address, direction) from the closed-form address rules.
    task automatic build_list();
        logic [15:0]       l;
        logic [ADDR_W-1:0] a;
        exp_t              e;
        l = 16'hACE1;
        exp_q.delete();
        for (int k = 0; k < int'(cnt); k++) begin
            case (amode)
                AddrInc:  a = ADDR_W'(int'(base) + k * int'(burst));
                AddrRun1: a = ADDR_W'(1) << (k % ADDR_W);
                AddrRun0: a = ~(ADDR_W'(1) << (k % ADDR_W));
                AddrRnd:  a = l[ADDR_W-1:0];
                default:  a = base;
            endcase
            if (tmode != TestReadOnly) begin
                e.addr = a; e.wr = 1'b1; exp_q.push_back(e);
            end
            if (tmode != TestWriteOnly) begin
                e.addr = a; e.wr = 1'b0; exp_q.push_back(e);
            end
            l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
        end
    endtask

    task automatic compare();
        if (valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (done === 1'b1) done_cyc = cyc;
        chk("valid", valid, m_valid);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        if (m_valid) begin
            if (exp_q.size() == 0) begin
                chk("model_queue", 1, 0);
            end else begin
                chk("addr", pkt.addr, exp_q[0].addr);
                chk("wr", wr, exp_q[0].wr);
                chk("burst", pkt.burst, e_burst);
                chk("smask", pkt.start_mask, e_smask);
                chk("emask", pkt.end_mask, e_emask);
                chk("ptrn", pkt.data_ptrn, e_ptrn);
                chk("ptrn_type", pkt.data_ptrn_type, e_dmode);
            end
        end
    endtask

    task automatic model_update(input logic rdy, cpl, stp, sta, rs);
        logic hs, rd;
        int   n_outst;
        if (rs) begin
            m_phase = PIdle; m_valid = 0; m_busy = 0; m_done = 0; m_outst = 0;
            return;
        end
        hs = m_valid && rdy;
        rd = hs && !exp_q[0].wr;
        if (hs) begin
            run_hs++; last_hs_cyc = cyc;
            if (rd) run_rd++;
        end
        if (cpl && m_outst > 0) cpl_eff++;
        n_outst = m_outst + (rd ? 1 : 0) - ((cpl && m_outst > 0) ? 1 : 0);
        if (stp && m_phase != PIdle) begin
            m_phase = PIdle; m_valid = 0; m_busy = 0; m_done = 0; m_outst = 0;
            return;
        end
        m_done = 0;
        case (m_phase)
            PIdle: if (sta && tmode != TestNone) begin
                m_phase = PLoad; m_busy = 1;
                build_list();
                e_burst = burst; e_smask = smask; e_emask = emask; e_ptrn = ptrn;
                e_dmode = dmode;
            end
            PLoad: if (exp_q.size() == 0) begin
                m_phase = PDone; m_done = 1;
            end else begin
                m_phase = PIssue; m_valid = 1;
            end
            PIssue: begin
                if (hs) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) begin
                        m_valid = 0; m_phase = PDrain;
                    end else begin
                        m_valid = exp_q[0].wr || n_outst < 255;
                    end
                end else if (!m_valid) begin
                    m_valid = exp_q[0].wr || n_outst < 255;
                end
            end
            PDrain: if (m_outst == 0) begin
                m_phase = PDone; m_done = 1;
            end
            default: begin
                m_phase = PIdle; m_busy = 0;
            end
        endcase
        m_outst = n_outst;
    endtask

    task automatic step(input logic rdy, cpl, stp, sta, rs);
        compare();
        ready = rdy; rd_cpl = cpl; stop = stp; start = sta; rst = rs;
        model_update(rdy, cpl, stp, sta, rs);
        @(negedge clk);
        cyc++;
    endtask

    task automatic start_run(input test_mode_type tm, input addr_mode_type am,
                             input int b, input int bu, input int c);
        tmode = tm; amode = am; base = ADDR_W'(b); burst = AMM_BURST_W'(bu); cnt = c;
        smask = BYTE_PER_WORD'($urandom); emask = BYTE_PER_WORD'($urandom);
        ptrn = 8'($urandom); dmode = data_mode_type'($urandom_range(0, 1));
        start_cyc = cyc; first_valid_cyc = -1; done_cyc = -1; last_hs_cyc = -1;
        run_hs = 0; run_rd = 0; cpl_eff = 0;
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic run_to_idle(input int maxc, input int rmode, input int cmode);
        int   n;
        logic r, c;
        n = 0;
        while (m_phase != PIdle && n < maxc) begin
            r = (rmode == 0) ? 1'b1 : (rmode == 1) ? logic'(n % 2 == 0)
                                                   : logic'($urandom_range(0, 3) != 0);
            c = (cmode == 0) ? 1'b0 : (cmode == 1) ? logic'(m_outst > 0 && $urandom_range(0, 2) == 0)
                                                   : logic'($urandom_range(0, 3) == 0);
            step(r, c, 1'b0, logic'($urandom_range(0, 7) == 0), 1'b0);
            n++;
        end
        if (m_phase != PIdle) chk("run_timeout", 1, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1; start = 0; stop = 0; ready = 0; rd_cpl = 0;
        tmode = TestNone; amode = AddrFix; dmode = DataFixed; base = '0; burst = '0; cnt = '0;
        smask = '0; emask = '0; ptrn = '0;
        m_phase = PIdle; m_valid = 0; m_busy = 0; m_done = 0; m_outst = 0;
        repeat (3) @(negedge clk);
        chk("reset_pkt", pkt, 0);
        chk("reset_wr", wr, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Write-only incrementing addresses.
        start_run(TestWriteOnly, AddrInc, 3, 4, 5);
        chk("inc_len", exp_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk("inc_addr_lit", exp_q[i].addr, lit_inc[i]);
            chk("inc_wr_lit", exp_q[i].wr, 1);
        end
        run_to_idle(100, 0, 0);
        chk("inc_hs_count", run_hs, 5);
        chk("start_to_valid", first_valid_cyc - start_cyc, 2);
        chk("last_hs_to_done", done_cyc - last_hs_cyc, 2);

        // Write-and-check at a fixed address with toggling ready.
        start_run(TestWriteAndCheck, AddrFix, 10, 2, 2);
        chk("wac_len", exp_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("wac_addr_lit", exp_q[i].addr, 10);
            chk("wac_wr_lit", exp_q[i].wr, (i % 2 == 0) ? 1 : 0);
        end
        run_to_idle(200, 1, 1);
        chk("wac_cpl_count", cpl_eff, 2);

        // Walking one, then walking zero.
        start_run(TestWriteOnly, AddrRun1, 0, 1, 8);
        for (int i = 0; i < 8; i++) chk("run1_addr_lit", exp_q[i].addr, lit_run1[i]);
        run_to_idle(100, 2, 0);
        start_run(TestReadOnly, AddrRun0, 0, 1, 8);
        for (int i = 0; i < 8; i++) chk("run0_addr_lit", exp_q[i].addr, (~lit_run1[i]) & 63);
        run_to_idle(200, 2, 1);

        // Outstanding-read ceiling.
        start_run(TestReadOnly, AddrInc, 0, 1, 300);
        repeat (270) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reads_before_stall", run_rd, 255);
        chk("stall_valid", valid, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("restall_valid", valid, 0);
        chk("reads_after_resume", run_rd, 257);
        run_to_idle(5000, 0, 1);
        chk("ro300_reads", run_rd, 300);

        // Zero-count run and ignored test-mode-0 start.
        start_run(TestWriteOnly, AddrFix, 5, 1, 0);
        run_to_idle(20, 0, 0);
        chk("cnt0_done_latency", done_cyc - start_cyc, 2);
        chk("cnt0_no_valid", first_valid_cyc, -1);
        start_run(TestNone, AddrFix, 5, 1, 4);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mode0_busy", busy, 0);

        // Stop mid-issue.
        start_run(TestWriteOnly, AddrInc, 1, 2, 50);
        repeat (10) step(logic'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("stop_valid", valid, 0);
        chk("stop_busy", busy, 0);
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("stop_no_done", done_cyc, -1);

        // Reset while draining.
        start_run(TestReadOnly, AddrInc, 2, 3, 4);
        repeat (8) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("drain_busy", busy, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr", wr, 0);
        chk("rst_pkt", pkt, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized runs.
        for (int r = 0; r < 8; r++) begin
            start_run(test_mode_type'($urandom_range(1, 3)), addr_mode_type'($urandom_range(0, 4)),
                      $urandom_range(0, 63), $urandom_range(1, 2047), $urandom_range(1, 40));
            run_to_idle(3000, 2, (r % 2 == 0) ? 1 : 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
